// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM stage load/store unit: memop codes,
// FSM state codes and the global reset/zero constants.
package mem_stage_lsu_pkg;

  localparam int unsigned MEMOP_W = 4;

  localparam logic        RstEnable = 1'b1;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

  typedef enum logic [MEMOP_W-1:0] {
    MEMOP_NONE = 4'd0,
    MEMOP_LB   = 4'd1,
    MEMOP_LBU  = 4'd2,
    MEMOP_LH   = 4'd3,
    MEMOP_LHU  = 4'd4,
    MEMOP_LW   = 4'd5,
    MEMOP_SB   = 4'd6,
    MEMOP_SH   = 4'd7,
    MEMOP_SW   = 4'd8
  } memop_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } lsu_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the LSU: store lane masks and data replication,
// load lane extraction with sign/zero extension, and the misalign flag.
module mem_lane_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [MEMOP_W-1:0] i_memop,
  input  logic [1:0]         i_addr_lo,
  input  logic [31:0]        i_storedata,
  input  logic [31:0]        i_rdata,
  output logic               o_is_load,
  output logic               o_is_store,
  output logic               o_misalign,
  output logic [3:0]         o_be,
  output logic [31:0]        o_wdata,
  output logic [31:0]        o_ldata
);

  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Decode the op into lane mask, store replication and load extension
  always_comb begin
    w_shift    = i_rdata >> {i_addr_lo, 3'b000};
    w_byte     = w_shift[7:0];
    w_half     = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_is_load  = 1'b0;
    o_is_store = 1'b0;
    o_misalign = 1'b0;
    o_be       = '0;
    o_wdata    = i_storedata;
    o_ldata    = i_rdata;
    case (i_memop)
      MEMOP_LB: begin
        o_is_load = 1'b1;
        o_be      = 4'b0001 << i_addr_lo;
        o_ldata   = {{24{w_byte[7]}}, w_byte};
      end
      MEMOP_LBU: begin
        o_is_load = 1'b1;
        o_be      = 4'b0001 << i_addr_lo;
        o_ldata   = {24'h0, w_byte};
      end
      MEMOP_LH: begin
        o_is_load  = 1'b1;
        o_misalign = i_addr_lo[0];
        o_be       = 4'b0011 << i_addr_lo;
        o_ldata    = {{16{w_half[15]}}, w_half};
      end
      MEMOP_LHU: begin
        o_is_load  = 1'b1;
        o_misalign = i_addr_lo[0];
        o_be       = 4'b0011 << i_addr_lo;
        o_ldata    = {16'h0, w_half};
      end
      MEMOP_LW: begin
        o_is_load  = 1'b1;
        o_misalign = |i_addr_lo;
        o_be       = 4'b1111;
      end
      MEMOP_SB: begin
        o_is_store = 1'b1;
        o_be       = 4'b0001 << i_addr_lo;
        o_wdata    = {4{i_storedata[7:0]}};
      end
      MEMOP_SH: begin
        o_is_store = 1'b1;
        o_misalign = i_addr_lo[0];
        o_be       = 4'b0011 << i_addr_lo;
        o_wdata    = {2{i_storedata[15:0]}};
      end
      MEMOP_SW: begin
        o_is_store = 1'b1;
        o_misalign = |i_addr_lo;
        o_be       = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: registered MEM/WB boundary plus a load/store unit
// driving a req/ack data bus, with misalign and ack-timeout exceptions.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ex_waddr_i,
  input  logic [31:0]           ex_wdata_i,
  input  logic                  ex_we_i,
  input  logic [MEMOP_W-1:0]    ex_memop_i,
  input  logic [ADDR_W-1:0]     ex_memaddr_i,
  input  logic [31:0]           ex_storedata_i,
  output logic                  stall_o,
  output logic                  dm_req_o,
  output logic                  dm_wr_o,
  output logic [3:0]            dm_be_o,
  output logic [ADDR_W-1:0]     dm_addr_o,
  output logic [31:0]           dm_wdata_o,
  input  logic                  dm_ack_i,
  input  logic [31:0]           dm_rdata_i,
  output logic [REG_ADDR_W-1:0] wb_waddr_o,
  output logic [31:0]           wb_wdata_o,
  output logic                  wb_we_o,
  output logic                  excp_adel_o,
  output logic                  excp_ades_o,
  output logic                  excp_bus_o
);

  localparam int unsigned      CNT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  lsu_state_e r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;

  logic                  r_dm_req, r_dm_wr;
  logic [3:0]            r_dm_be;
  logic [ADDR_W-1:0]     r_dm_addr;
  logic [31:0]           r_dm_wdata;
  logic [REG_ADDR_W-1:0] r_wb_waddr;
  logic [31:0]           r_wb_wdata;
  logic                  r_wb_we;
  logic                  r_adel, r_ades, r_bus;

  logic        w_is_load, w_is_store, w_is_mem, w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_st_wdata, w_ldata;
  logic        w_stall, w_issue, w_mis_ev, w_ack_done, w_tmo;

  // EX inputs are held while stalled, so one decoder serves issue and completion
  mem_lane_align u_align (
    .i_memop     (ex_memop_i),
    .i_addr_lo   (ex_memaddr_i[1:0]),
    .i_storedata (ex_storedata_i),
    .i_rdata     (dm_rdata_i),
    .o_is_load   (w_is_load),
    .o_is_store  (w_is_store),
    .o_misalign  (w_misalign),
    .o_be        (w_be),
    .o_wdata     (w_st_wdata),
    .o_ldata     (w_ldata)
  );

  assign w_is_mem = w_is_load | w_is_store;

  // Next-state, stall and event decode
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_issue     = 1'b0;
    w_mis_ev    = 1'b0;
    w_ack_done  = 1'b0;
    w_tmo       = 1'b0;
    if (rst != RstEnable) begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_mem) begin
            if (w_misalign) begin
              w_mis_ev = 1'b1;
            end else begin
              w_issue     = 1'b1;
              w_stall     = 1'b1;
              w_state_nxt = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          w_stall = !dm_ack_i;
          if (dm_ack_i) begin
            w_ack_done  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            w_tmo       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst == RstEnable) r_state <= ST_IDLE;
    else                  r_state <= w_state_nxt;
  end

  // Bus, writeback, exception and timeout registers
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_cnt      <= '0;
      r_dm_req   <= 1'b0;
      r_dm_wr    <= 1'b0;
      r_dm_be    <= '0;
      r_dm_addr  <= '0;
      r_dm_wdata <= ZeroWord;
      r_wb_waddr <= '0;
      r_wb_wdata <= ZeroWord;
      r_wb_we    <= 1'b0;
      r_adel     <= 1'b0;
      r_ades     <= 1'b0;
      r_bus      <= 1'b0;
    end else begin
      r_adel <= 1'b0;
      r_ades <= 1'b0;
      r_bus  <= 1'b0;
      if (r_state == ST_IDLE) begin
        r_cnt      <= '0;
        r_dm_req   <= 1'b0;
        r_wb_waddr <= ex_waddr_i;
        r_wb_wdata <= ex_wdata_i;
        r_wb_we    <= w_is_mem ? 1'b0 : ex_we_i;
        if (w_issue) begin
          r_dm_req   <= 1'b1;
          r_dm_wr    <= w_is_store;
          r_dm_be    <= w_be;
          r_dm_addr  <= ex_memaddr_i;
          r_dm_wdata <= w_st_wdata;
        end
        if (w_mis_ev) begin
          r_adel <= w_is_load;
          r_ades <= w_is_store;
        end
      end else begin
        r_wb_we <= 1'b0;
        if (w_ack_done) begin
          r_dm_req <= 1'b0;
          if (w_is_load) begin
            r_wb_waddr <= ex_waddr_i;
            r_wb_wdata <= w_ldata;
            r_wb_we    <= ex_we_i;
          end
        end else if (w_tmo) begin
          r_dm_req <= 1'b0;
          r_bus    <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign stall_o     = w_stall;
  assign dm_req_o    = r_dm_req;
  assign dm_wr_o     = r_dm_wr;
  assign dm_be_o     = r_dm_be;
  assign dm_addr_o   = r_dm_addr;
  assign dm_wdata_o  = r_dm_wdata;
  assign wb_waddr_o  = r_wb_waddr;
  assign wb_wdata_o  = r_wb_wdata;
  assign wb_we_o     = r_wb_we;
  assign excp_adel_o = r_adel;
  assign excp_ades_o = r_ades;
  assign excp_bus_o  = r_bus;

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Next-generation MEM pipeline stage for the 5-stage core. Replaces the pure EX/MEM-to-WB passthrough with a registered MEM/WB boundary plus a load/store unit.
- Drives a req/ack data-memory bus with byte lanes, sign/zero-extends loads, and stalls the pipeline while an access is outstanding.
- Detects misaligned accesses and bus timeouts.

Parameters:
- ADDR_W, 32, data-memory byte-address width.
- REG_ADDR_W, 5, register-file address width.
- ACK_TIMEOUT, 16, maximum wait cycles for dm_ack_i before a bus error; legal range >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- ex_waddr_i  in  REG_ADDR_W  destination register.
- ex_wdata_i  in  32  ALU result.
- ex_we_i  in  1  register write enable.
- ex_memop_i  in  4  memory op: 0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE.
- ex_memaddr_i  in  ADDR_W  effective byte address.
- ex_storedata_i  in  32  store source (rt).
- stall_o  out  1  pipeline stall request to ctrl; combinational.
- dm_req_o  out  1  bus request.
- dm_wr_o  out  1  1 = store.
- dm_be_o  out  4  byte enables, little-endian.
- dm_addr_o  out  ADDR_W  byte address.
- dm_wdata_o  out  32  lane-replicated store data.
- dm_ack_i  in  1  single-cycle access complete.
- dm_rdata_i  in  32  read data, valid with ack.
- wb_waddr_o  out  REG_ADDR_W  registered.
- wb_wdata_o  out  32  registered.
- wb_we_o  out  1  registered.
- excp_adel_o  out  1  1-cycle pulse, misaligned load.
- excp_ades_o  out  1  1-cycle pulse, misaligned store.
- excp_bus_o  out  1  1-cycle pulse, ack timeout.

Behaviour:
- Reset (synchronous, active-high, takes priority over all else):
  - state <= IDLE, timeout counter <= 0.
  - All registered outputs go to 0: wb_*, dm_req_o/dm_wr_o/dm_be_o/dm_addr_o/dm_wdata_o, excp_*.
  - stall_o reads 0 while rst is high.
- Upstream contract: EX inputs are held stable while stall_o = 1.
- FSM has two states, IDLE and WAIT. All bus outputs are registered.
- IDLE with NONE:
  - wb_* <= ex_* at the next edge.
  - Latency 1 cycle, stall_o = 0.
- IDLE with a load/store, aligned:
  - Aligned means LH/LHU/SH need addr[0] = 0; LW/SW need addr[1:0] = 0; byte ops are always aligned.
  - stall_o = 1 combinationally.
  - Next edge: state <= WAIT, dm_req_o <= 1, dm_addr_o <= addr.
  - dm_wr_o <= store.
  - dm_be_o <= lane mask: byte 0001 << a[1:0]; half 0011 << a[1:0]; word 1111. Loads also drive the mask.
  - dm_wdata_o <= SB {4{b}}, SH {2{h}}, SW word.
  - wb_we_o <= 0 (bubble). Counter <= 0.
- IDLE with a load/store, misaligned:
  - No bus request, stall_o = 0.
  - Next edge: excp_adel_o or excp_ades_o <= 1 for one cycle; wb_we_o <= 0.
- WAIT:
  - dm_* held stable.
  - stall_o = !dm_ack_i.
  - Counter increments each cycle without ack.
- WAIT, dm_ack_i = 1:
  - Next edge: dm_req_o <= 0, state <= IDLE.
  - Loads: wb_wdata_o <= selected lane (byte by a[1:0], half by a[1]).
    - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the full word.
    - wb_we_o <= ex_we_i.
  - Stores: wb_we_o <= 0.
- WAIT, no ack, counter == ACK_TIMEOUT-1:
  - Next edge: dm_req_o <= 0, excp_bus_o <= 1 pulse, wb_we_o <= 0, state <= IDLE.
  - stall_o is still 1 in this final cycle.
- Ack arriving in the same cycle as the timeout condition: the ack wins and no error is raised.
- Ack while in IDLE is ignored; this covers a stale ack after reset or timeout.
- Reset mid-WAIT: dm_req_o drops at that edge and no writeback occurs.
- Back-to-back memory ops: returning to IDLE with a new op presented in the same cycle costs one IDLE cycle.
  - Minimum load latency is 3 cycles, presentation to wb valid.
- wb_* change only at clock edges. wb_we_o is 0 in every bubble cycle.

Decomposition:
- Shared package/defines: memop encodings and MEMOP_W = 4; FSM state codes; RstEnable and ZeroWord kept consistent with the existing global defines.
- One sub-module: mem_lane_align, purely combinational. It produces store be/wdata replication, load extract/extend, and the misalign flag.

Test Plan:
- NONE op with waddr=3, wdata=0xDEADBEEF, we=1 -> wb_* match one cycle later; stall_o stays 0.
- LB at addr 0x1003, ack after 2 wait cycles, rdata=0x80FF_0000 -> dm_be_o=1000; stall_o high 3 cycles; wb_wdata_o=0xFFFFFF80.
- SH at 0x2002 with data 0x0000ABCD, ack immediate -> dm_be_o=1100, dm_wdata_o=0xABCDABCD, dm_wr_o=1; wb_we_o=0.
- LW at 0x3001 -> excp_adel_o pulses one cycle, dm_req_o never asserts, stall_o=0.
- LW, ACK_TIMEOUT=4, no ack -> dm_req_o high for 4 cycles, then excp_bus_o pulse; a late ack in IDLE causes no write.
- rst asserted in the 2nd WAIT cycle -> next edge: dm_req_o=0, wb_we_o=0, state IDLE; a following NONE op passes normally.
